// File: rtl/shift_chain_pkg.sv
// Shared state encoding and size helpers for the shift-chain loader.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int nwords(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

  function automatic int last_len(input int len, input int w);
    return len - (nwords(len, w) - 1) * w;
  endfunction

endpackage

// File: rtl/shift_chain_ser.sv
// Word serializer: holds one word, emits bit 0 first, one bit per cycle while hold_vld.
// Flags the last bit of the held word so a new word can load in the same cycle.
module shift_chain_ser
  import shift_chain_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LW     = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LW-1:0]     load_len,
  output logic              hold_vld,
  output logic              bit_out,
  output logic              last
);

  logic [WORD_W-1:0] hold_q, hold_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              hold_vld_q, hold_vld_d;

  assign hold_vld = hold_vld_q;
  assign bit_out  = hold_vld_q & hold_q[0];
  assign last     = hold_vld_q && (idx_q == len_q - LW'(1));

  always_comb begin
    hold_d     = hold_q;
    idx_d      = idx_q;
    len_d      = len_q;
    hold_vld_d = hold_vld_q;
    if (hold_vld_q) begin
      hold_d = hold_q >> 1;
      idx_d  = idx_q + LW'(1);
      if (last) begin
        hold_vld_d = 1'b0;
      end
    end
    if (load) begin
      hold_d     = load_data;
      idx_d      = '0;
      len_d      = load_len;
      hold_vld_d = 1'b1;
    end
    // Clear wins over a same-cycle load so an aborted transfer leaves nothing behind.
    if (clr) begin
      hold_d     = '0;
      idx_d      = '0;
      len_d      = '0;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      hold_vld_q <= hold_vld_d;
    end
  end

endmodule

// File: rtl/shift_chain_loader.sv
// Streams CHAIN_LEN bits LSB-first from valid/ready words into a serial chain, then pulses done.
// SHIFT_CHAIN_LOADER_READBACK_EN adds chain_dout capture packed into rb_data/rb_valid words.
module shift_chain_loader
  import shift_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 8192,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
  input  logic              chain_dout,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              chain_din,
  output logic              chain_en,
  output logic              busy,
  output logic              done
);

  localparam int NW   = nwords(CHAIN_LEN, WORD_W);
  localparam int LAST = last_len(CHAIN_LEN, WORD_W);
  localparam int CW   = cnt_w(CHAIN_LEN);
  localparam int WCW  = cnt_w(NW);
  localparam int LW   = cnt_w(WORD_W);

  state_e         state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           hold_vld, ser_bit, ser_last;
  logic           accept, ser_clr, abort_act, last_bit;
  logic [LW-1:0]  load_len;

  assign abort_act  = abort && (state_q != IDLE);
  assign last_bit   = hold_vld && (bit_cnt_q == CW'(CHAIN_LEN - 1));
  assign word_ready = (state_q == SHIFT) && (word_cnt_q < WCW'(NW)) && (!hold_vld || ser_last);
  assign accept     = word_valid && word_ready;
  assign ser_clr    = ((state_q == IDLE) && start) || abort_act;
  // Only the final word may be short; its upper bits are never shifted.
  assign load_len   = (word_cnt_q == WCW'(NW - 1)) ? LW'(LAST) : LW'(WORD_W);

  assign chain_en  = hold_vld;
  assign chain_din = ser_bit;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) && !abort;

  shift_chain_ser #(.WORD_W(WORD_W)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ser_clr),
    .load      (accept),
    .load_data (word_data),
    .load_len  (load_len),
    .hold_vld  (hold_vld),
    .bit_out   (ser_bit),
    .last      (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      SHIFT: begin
        bit_cnt_d  = bit_cnt_q + CW'(hold_vld);
        word_cnt_d = word_cnt_q + WCW'(accept);
        // Abort still lets the final bit go out, but skips the DONE pulse.
        if (abort) begin
          state_d = IDLE;
        end else if (last_bit) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
  logic [WORD_W-1:0] acc_q, acc_d, acc_nxt;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic [LW-1:0]     acc_cnt_q, acc_cnt_d;
  logic              rb_valid_q, rb_valid_d;

  assign acc_nxt  = acc_q | (WORD_W'(chain_dout) << acc_cnt_q);
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

  always_comb begin
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (hold_vld) begin
      acc_d     = acc_nxt;
      acc_cnt_d = acc_cnt_q + LW'(1);
      if ((acc_cnt_q == LW'(WORD_W - 1)) || last_bit) begin
        rb_data_d  = acc_nxt;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        acc_cnt_d  = '0;
      end
    end
    if (abort_act) begin
      acc_d      = '0;
      acc_cnt_d  = '0;
      rb_data_d  = '0;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_chain_loader.sv
// Drives three loader instances (40x8, 20x8 partial last word, default 8192x32) against a bit-stream model.
module tb_shift_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start[3], abort[3], word_valid[3], word_ready[3];
  logic        chain_din[3], chain_en[3], busy[3], done[3];
  logic [31:0] word_data[3];
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
  logic        chain_dout[3];
  logic [31:0] rb_data[3];
  logic        rb_valid[3];
`endif

  int cl[3] = '{40, 20, 8192};
  int ww[3] = '{8, 8, 32};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 40 : (g == 1) ? 20 : 8192;
    localparam int W = (g == 2) ? 32 : 8;
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    logic [W-1:0] rb_w;
    assign rb_data[g] = 32'(rb_w);
`endif
    shift_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .abort      (abort[g]),
      .word_data  (W'(word_data[g])),
      .word_valid (word_valid[g]),
      .word_ready (word_ready[g]),
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
      .chain_dout (chain_dout[g]),
      .rb_data    (rb_w),
      .rb_valid   (rb_valid[g]),
`endif
      .chain_din  (chain_din[g]),
      .chain_en   (chain_en[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] src[$];
  bit          exp_q[$], got_q[$], chain_m[$];
  logic [31:0] rb_exp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string nm, input int k);
    check({nm, "_word_ready"}, word_ready[k], 0);
    check({nm, "_chain_din"},  chain_din[k],  0);
    check({nm, "_chain_en"},   chain_en[k],   0);
    check({nm, "_busy"},       busy[k],       0);
    check({nm, "_done"},       done[k],       0);
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    check({nm, "_rb_valid"},   rb_valid[k],   0);
    check({nm, "_rb_data"},    rb_data[k],    0);
`endif
  endtask

  // One load on instance k. Words come from src; the model expects the first
  // cl[k] bits of the concatenated words (each LSB-first) on chain_din.
  // abort_at >= 0 aborts after that many shifts; rst_at >= 0 resets after that
  // many shifts, rst_at == -2 resets in the done cycle.
  task automatic run_load(input string nm, input int k, input bit rnd, input bit spam,
                          input int stall_after, input int stall_len,
                          input int abort_at, input int rst_at);
    int L, W, NW, nw, n_shift, n_acc, n_done, first, last, done_cyc, abort_cyc;
    int stall_left, nbad;
    bit stalled, fin, bsy_done, busy_after, rst_hit;
    logic [31:0] w;
    L = cl[k]; W = ww[k]; NW = (L + W - 1) / W; nw = src.size();
    exp_q.delete(); got_q.delete(); chain_m.delete(); rb_exp.delete();
    for (int i = 0; i < nw && exp_q.size() < L; i++)
      for (int b = 0; b < W && exp_q.size() < L; b++) exp_q.push_back(src[i][b]);
    for (int i = 0; i < L; i++) chain_m.push_back(1'($urandom_range(1)));
    for (int i = 0; i < L; i += W) begin
      w = '0;
      for (int j = 0; j < W && i + j < L; j++) w[j] = chain_m[L-1-i-j];
      rb_exp.push_back(w);
    end
    n_shift = 0; n_acc = 0; n_done = 0; first = -1; last = -1; done_cyc = -1; abort_cyc = -1;
    stall_left = 0; stalled = 0; fin = 0; bsy_done = 0; busy_after = 1; rst_hit = 0;

    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(negedge clk);
      start[k] = (cyc == 0) || (spam && busy[k]);
      abort[k] = (abort_at >= 0) && (abort_cyc < 0) && (n_shift == abort_at);
      if (!stalled && stall_len > 0 && n_acc == stall_after && word_ready[k]) begin
        stalled = 1; stall_left = stall_len;
      end
      word_valid[k] = (src.size() > 0) && (stall_left == 0) && (!rnd || $urandom_range(3) != 0);
      if (stall_left > 0) stall_left--;
      word_data[k] = (src.size() > 0) ? src[0] : $urandom();
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
      chain_dout[k] = chain_m[L-1];
`endif
      #1;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        check({nm, "_post_abort_busy"},  busy[k],       0);
        check({nm, "_post_abort_ready"}, word_ready[k], 0);
        check({nm, "_post_abort_en"},    chain_en[k],   0);
      end
      if (chain_en[k]) begin
        got_q.push_back(chain_din[k]);
        chain_m.push_front(chain_din[k]);
        void'(chain_m.pop_back());
        n_shift++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (done[k]) begin
        n_done++; done_cyc = cyc; bsy_done = busy[k];
      end
      if (word_valid[k] && word_ready[k]) begin
        void'(src.pop_front());
        n_acc++;
      end
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
      if (rb_valid[k] && abort_at < 0 && rst_at == -1) begin
        if (rb_exp.size() > 0) check({nm, "_rb_data"}, rb_data[k], rb_exp.pop_front());
        else check({nm, "_rb_extra_pulse"}, 1, 0);
      end
`endif
      if (abort[k]) abort_cyc = cyc;
      if ((rst_at >= 0 && n_shift == rst_at) || (rst_at == -2 && done[k])) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs({nm, "_rst"}, k);
        rst_hit = 1; fin = 1;
        @(negedge clk);
        start[k] = 0; abort[k] = 0; word_valid[k] = 0;
        rst_n = 1'b1;
      end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy[k]; fin = 1;
      end else if (abort_cyc >= 0 && cyc == abort_cyc + 4) begin
        fin = 1;
      end
    end
    start[k] = 0; abort[k] = 0; word_valid[k] = 0;

    check({nm, "_finished"}, fin, 1);
    if (rst_hit) return;
    if (abort_at >= 0) begin
      check({nm, "_abort_shifts"}, n_shift, abort_at + 1);
      check({nm, "_abort_no_done"}, n_done, 0);
      return;
    end
    nbad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] != exp_q[i]) nbad++;
    check({nm, "_shifts"},      n_shift, L);
    check({nm, "_bad_bits"},    nbad, 0);
    check({nm, "_accepted"},    n_acc, (nw < NW) ? nw : NW);
    check({nm, "_done_pulses"}, n_done, 1);
    check({nm, "_done_lat"},    done_cyc - last, 1);
    check({nm, "_busy_done"},   bsy_done, 1);
    check({nm, "_busy_after"},  busy_after, 0);
    if (!rnd) check({nm, "_gap"}, (last - first + 1) - n_shift, stall_len);
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    check({nm, "_rb_missing"}, rb_exp.size(), 0);
`endif
  endtask

  task automatic fill_random(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back($urandom());
  endtask

  logic [3:0] tail;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 0; abort[k] = 0; word_valid[k] = 0; word_data[k] = '0;
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
      chain_dout[k] = 0;
`endif
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_zero_outputs($sformatf("reset%0d", k), k);
    rst_n = 1'b1;

    src.delete();
    for (int i = 1; i <= 5; i++) src.push_back(32'(i));
    run_load("contig", 0, 0, 0, -1, 0, -1, -1);

    src.delete();
    src.push_back(32'hFF); src.push_back(32'h00); src.push_back(32'hAB); src.push_back(32'h5C);
    run_load("partial", 1, 0, 0, -1, 0, -1, -1);
    tail = 'x;
    if (got_q.size() >= 20) tail = {got_q[19], got_q[18], got_q[17], got_q[16]};
    check("partial_tail", tail, 4'hB);
    check("partial_4th_left", src.size(), 1);

    fill_random(5);
    run_load("stall", 0, 0, 1, 2, 5, -1, -1);

    fill_random(5);
    run_load("abort", 0, 0, 0, -1, 0, 13, -1);
    fill_random(5);
    run_load("post_abort", 0, 0, 0, -1, 0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      fill_random(3 + r % 2);
      run_load($sformatf("rand20_%0d", r), 1, 1, 1, -1, 0, -1, -1);
    end

    fill_random(256);
    run_load("full8192", 2, 1, 1, -1, 0, -1, -1);

    fill_random(5);
    run_load("rst_shift", 0, 0, 1, -1, 0, -1, 20);
    fill_random(5);
    run_load("rst_done", 0, 0, 1, -1, 0, -1, -2);
    fill_random(5);
    run_load("post_rst", 0, 1, 1, -1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_chain_loader.md
Name: shift_chain_loader

Overview:
- Sequencer that streams a bitstream into a long serial shift chain, such as an 8192-bit configuration or scan register.
- Accepts WORD_W-bit words over a valid/ready interface and serializes them LSB-first onto the chain's serial input.
- Gates the chain with a per-cycle shift enable and counts exactly CHAIN_LEN shifts, then pulses done.
- Sits between a bitstream source (FIFO/DMA) and the chain datapath.

Parameters:
- CHAIN_LEN, 8192: number of bits shifted per load; must be >= 1.
- WORD_W, 32: input word width; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  cancels an active load.
- word_data  input  WORD_W  next bitstream word; bit 0 is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- chain_din  output  1  serial data to chain shift_in.
- chain_en  output  1  chain shifts this cycle; qualifies chain_din.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse once CHAIN_LEN bits have been shifted.

Behaviour:
- Reset: state=IDLE; bit counter, word counter, hold register and hold-valid cleared.
- Reset values: word_ready=0, chain_din=0, chain_en=0, busy=0, done=0.
- Counters: bit_cnt width $clog2(CHAIN_LEN+1). NWORDS=ceil(CHAIN_LEN/WORD_W).
- IDLE:
  - start=1 -> SHIFT; clear bit_cnt, word counter and hold-valid.
  - Other inputs are ignored.
- SHIFT, hold register:
  - Hold register with bit index idx (0..WORD_W-1).
  - While hold-valid: chain_en=1 and chain_din=hold[idx], both combinational from registers.
  - Each shifting cycle increments idx and bit_cnt.
- SHIFT, word acceptance:
  - word_ready = (words accepted < NWORDS) and (!hold_valid or last shift of the held word this cycle).
  - Handshake: a word transfers when word_valid && word_ready. Data is held stable by the source until accepted.
  - Back-to-back words shift with no bubble: the first bit of the new word appears in the cycle after acceptance.
  - If no word is available, chain_en=0 and the chain stalls. Stall length is unbounded.
- SHIFT, final word:
  - The last word may be partial: only CHAIN_LEN-(NWORDS-1)*WORD_W low bits are shifted; upper bits are discarded.
  - The word is released when bit_cnt reaches CHAIN_LEN.
- SHIFT -> DONE: taken on the cycle the CHAIN_LEN-th bit is shifted. Total chain_en-high cycles equal CHAIN_LEN exactly.
- DONE:
  - done=1 for one cycle, busy=1, word_ready=0.
  - Next state IDLE.
  - start on this cycle is ignored.
- Abort:
  - abort=1 in SHIFT or DONE -> IDLE next cycle; hold cleared; done not asserted.
  - chain_en is 0 from the next cycle on.
  - abort outranks completion in the same cycle: that final bit is still shifted, but done is suppressed.
- start while busy: ignored.
- Reset mid-load: immediate return to reset state. Chain contents are undefined and not the block's concern.

Optional Feature:
- Macro: SHIFT_CHAIN_LOADER_READBACK_EN.
- With the macro, added ports:
  - chain_dout input 1: the chain's shift_out.
  - rb_data output WORD_W.
  - rb_valid output 1.
- With the macro, behaviour:
  - On every chain_en cycle, chain_dout is sampled and packed LSB-first into a WORD_W accumulator.
  - rb_valid pulses one cycle after each full word, and after the final partial word (zero-padded).
  - rb_data holds its value until the next pulse. No backpressure.
  - Reset/abort: accumulator cleared, rb_data=0, rb_valid=0.
- Without the macro: no readback ports and no readback logic.

Decomposition:
- Package shift_chain_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Width helper function for counters.
  - NWORDS and last-word-length computation as localparam functions.
- Sub-module shift_chain_ser: hold register, idx counter, load/advance/last handshake.
- The top level keeps the FSM, bit and word counters, and the readback option.

Test Plan:
1. CHAIN_LEN=40, WORD_W=8, source always valid with words 0x01..0x05; start -> exactly 40 chain_en cycles in one contiguous run.
   - chain_din sequence is bit0-first of each word.
   - done pulses on the cycle after the 40th shift; busy falls with it.
2. CHAIN_LEN=20, WORD_W=8, words 0xFF,0x00,0xAB -> exactly 3 words accepted and 20 shifts.
   - The last four bits are 1,1,0,1 (0xB LSB-first); 0xA is discarded.
   - A 4th word_valid is never accepted.
3. Stall: word_valid dropped for 5 cycles mid-stream -> chain_en=0 for exactly those cycles; no bit lost or duplicated; total shifts=40.
4. abort asserted after 13 shifts -> IDLE next cycle, no done, word_ready=0.
   - A following start performs a full clean 40-bit load.
5. Default params, 256 random words, chain loopback model -> model contents equal the input stream; done after 8192 shifts.
   - Readback build: 256 rb_valid pulses, whose rb_data equal the prior contents.
6. rst_n asserted mid-SHIFT and mid-DONE -> all outputs 0 immediately. start during busy/DONE has no effect.
